// File: rtl/tm1638_key_reader_if.sv
// Bundles the key reader's request/result handshake with the TM1638 STB/CLK/DIO pins.
// master: the key reader (drives the TM1638 bus and the results).
// slave: the surrounding logic (issues start, supplies the DIO pad input).
interface tm1638_key_reader_if;
  logic        start;
  logic        tm_stb;
  logic        tm_clk;
  logic        tm_dio_out;
  logic        tm_dio_oe;
  logic        tm_dio_in;
  logic        busy;
  logic        done;
  logic        key_change;
  logic [31:0] scan;
  logic [7:0]  keys;

  modport master (
    input  start, tm_dio_in,
    output tm_stb, tm_clk, tm_dio_out, tm_dio_oe,
    output busy, done, key_change, scan, keys
  );

  modport slave (
    output start, tm_dio_in,
    input  tm_stb, tm_clk, tm_dio_out, tm_dio_oe,
    input  busy, done, key_change, scan, keys
  );
endinterface

// File: rtl/tm1638_key_reader.sv
// Reads the TM1638 key matrix: sends the read-key command, then clocks in 4 scan bytes.
// Latency: start-accept to done pulse is (82+TWAIT)*CLK_DIV system cycles.
// Backpressure: none; start is only sampled while idle, and requests made while busy are dropped.
module tm1638_key_reader #(
  parameter int unsigned CLK_DIV = 32,
  parameter int unsigned TWAIT   = 2,
  parameter logic [7:0]  RD_CMD  = 8'h42
) (
  input  logic                       clkinput,
  input  logic                       rst_n,
  tm1638_key_reader_if.master        bus
);

  localparam int unsigned     CW         = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   TICK_LAST  = CW'(CLK_DIV - 1);
  localparam logic [5:0]      TWAIT_LAST = 6'(TWAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STB_LO,
    S_CMD,
    S_WAIT,
    S_READ,
    S_STB_HI
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;      // system cycles within the current tick
  logic [5:0]      idx;      // tick number within the current state
  logic [5:0]      idx_nxt;
  logic [31:0]     shift;
  logic [7:0]      keys_nxt;

  logic            stb_q;
  logic            clk_q;
  logic            dio_q;
  logic            oe_q;
  logic            busy_q;
  logic            done_q;
  logic            kc_q;
  logic [31:0]     scan_q;
  logic [7:0]      keys_q;

  // Each scan byte carries two keys: bit 0 -> even key, bit 4 -> odd key.
  function automatic logic [7:0] decode_keys(input logic [31:0] s);
    logic [7:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      d[2*i]   = s[8*i];
      d[2*i+1] = s[8*i+4];
    end
    return d;
  endfunction

  assign idx_nxt  = idx + 6'd1;
  assign keys_nxt = decode_keys(shift);

  // Sequencer: tick timing, bus waveform generation, DIO sampling and result publication.
  always_ff @(posedge clkinput or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      stb_q  <= 1'b1;
      clk_q  <= 1'b1;
      dio_q  <= 1'b1;
      oe_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      kc_q   <= 1'b0;
      scan_q <= '0;
      keys_q <= '0;
    end else begin
      done_q <= 1'b0;
      kc_q   <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.start) begin
          state  <= S_STB_LO;
          cnt    <= '0;
          idx    <= '0;
          shift  <= '0;
          busy_q <= 1'b1;
          stb_q  <= 1'b0;
          oe_q   <= 1'b1;
          dio_q  <= RD_CMD[0];
          clk_q  <= 1'b1;
        end
      end else if (cnt != TICK_LAST) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        case (state)
          S_STB_LO: begin
            state <= S_CMD;
            idx   <= '0;
            clk_q <= 1'b0;
            dio_q <= RD_CMD[0];
          end
          S_CMD: begin
            if (idx == 6'd15) begin
              // Release DIO while CLK is high so the chip can take over safely.
              state <= S_WAIT;
              idx   <= '0;
              clk_q <= 1'b1;
              oe_q  <= 1'b0;
              dio_q <= 1'b1;
            end else begin
              idx   <= idx_nxt;
              clk_q <= idx_nxt[0];
              // New bit is presented with the falling edge, held through the rise.
              if (!idx_nxt[0]) dio_q <= RD_CMD[idx_nxt[3:1]];
            end
          end
          S_WAIT: begin
            if (idx == TWAIT_LAST) begin
              state <= S_READ;
              idx   <= '0;
              clk_q <= 1'b0;
            end else begin
              idx <= idx_nxt;
            end
          end
          S_READ: begin
            // Sample at the end of each high half-period, LSB first.
            if (idx[0]) shift[idx[5:1]] <= bus.tm_dio_in;
            if (idx == 6'd63) begin
              state <= S_STB_HI;
              stb_q <= 1'b1;
              clk_q <= 1'b1;
            end else begin
              idx   <= idx_nxt;
              clk_q <= idx_nxt[0];
            end
          end
          S_STB_HI: begin
            state  <= S_IDLE;
            scan_q <= shift;
            keys_q <= keys_nxt;
            done_q <= 1'b1;
            kc_q   <= (keys_nxt != keys_q);
            busy_q <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.tm_stb     = stb_q;
  assign bus.tm_clk     = clk_q;
  assign bus.tm_dio_out = dio_q;
  assign bus.tm_dio_oe  = oe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.key_change = kc_q;
  assign bus.scan       = scan_q;
  assign bus.keys       = keys_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Bench for tm1638_key_reader: a TM1638 bus model serves queued scan words,
// and a scoreboard holds the expected scan/keys/key_change for each transaction.
module tb_tm1638_key_reader;

  localparam int CLK_DIV = 4;
  localparam int TWAIT   = 2;
  localparam int TXN     = (82 + TWAIT) * CLK_DIV;

  typedef struct {
    logic [31:0] scan;
    logic [7:0]  keys;
    logic        kc;
  } exp_t;

  logic clkinput = 1'b0;
  logic rst_n    = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  exp_t        exp_q[$];
  logic [31:0] bus_q[$];
  logic [7:0]  model_keys = '0;

  tm1638_key_reader_if bus ();

  tm1638_key_reader #(
    .CLK_DIV (CLK_DIV),
    .TWAIT   (TWAIT),
    .RD_CMD  (8'h42)
  ) dut (
    .clkinput (clkinput),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clkinput = ~clkinput;

  // TM1638 model: captures command bits on CMD rising edges, shifts out the word on read falls.
  logic        dio_drv  = 1'b1;
  logic        stb_prev = 1'b1;
  logic [31:0] cur_word = '1;
  logic [7:0]  cmd_bits = '0;
  int          rd_idx   = 0;
  int          rises    = 0;
  assign bus.tm_dio_in = dio_drv;

  always @(bus.tm_stb or bus.tm_clk) begin
    if (bus.tm_stb !== stb_prev) begin
      stb_prev = bus.tm_stb;
      dio_drv  = 1'b1;
      if (bus.tm_stb === 1'b0) begin
        cur_word = (bus_q.size() > 0) ? bus_q.pop_front() : '1;
        rd_idx   = 0;
        rises    = 0;
        cmd_bits = '0;
      end
    end else if (bus.tm_stb === 1'b0) begin
      if (bus.tm_clk === 1'b1 && bus.tm_dio_oe === 1'b1) begin
        if (rises < 8) cmd_bits[rises] = bus.tm_dio_out;
        rises++;
      end else if (bus.tm_clk === 1'b0 && bus.tm_dio_oe === 1'b0 && rd_idx < 32) begin
        dio_drv = cur_word[rd_idx];
        rd_idx++;
      end
    end
  end

  // STB monitor: length of the last high stretch and number of falling edges.
  int   hi_run = 0, last_hi_run = 0, stb_falls = 0;
  logic stb_s = 1'b1;
  always @(negedge clkinput) begin
    if (bus.tm_stb === 1'b1) begin
      hi_run++;
    end else begin
      if (hi_run > 0) last_hi_run = hi_run;
      hi_run = 0;
      if (stb_s === 1'b1) stb_falls++;
    end
    stb_s = bus.tm_stb;
  end

  function automatic logic [7:0] ref_keys(input logic [31:0] w);
    logic [7:0] k;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      k[2*i]   = w[8*i];
      k[2*i+1] = w[8*i+4];
    end
    return k;
  endfunction

  task automatic push_scan(input logic [31:0] w);
    exp_t e;
    e.scan     = w;
    e.keys     = ref_keys(w);
    e.kc       = (e.keys != model_keys);
    model_keys = e.keys;
    bus_q.push_back(w);
    exp_q.push_back(e);
  endtask

  task automatic start_pulse();
    @(negedge clkinput) bus.start = 1'b1;
    @(negedge clkinput) bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clkinput);
      if (bus.done === 1'b1) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e.scan = 'x; e.keys = 'x; e.kc = 1'bx;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    return e;
  endfunction

  task automatic test_reset();
    bus.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clkinput);
    rst_n = 1'b1;
    @(negedge clkinput);
    total++; if (bus.tm_stb !== 1'b1)     begin bad++; $display("FAIL reset_stb got=%b want=1", bus.tm_stb); end
    total++; if (bus.tm_clk !== 1'b1)     begin bad++; $display("FAIL reset_clk got=%b want=1", bus.tm_clk); end
    total++; if (bus.tm_dio_oe !== 1'b0)  begin bad++; $display("FAIL reset_oe got=%b want=0", bus.tm_dio_oe); end
    total++; if (bus.tm_dio_out !== 1'b1) begin bad++; $display("FAIL reset_dio got=%b want=1", bus.tm_dio_out); end
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0)       begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.scan !== 32'h0)      begin bad++; $display("FAIL reset_scan got=%h want=0", bus.scan); end
    total++; if (bus.keys !== 8'h0)       begin bad++; $display("FAIL reset_keys got=%h want=0", bus.keys); end
  endtask

  task automatic test_key_decode();
    int lat; bit ok; exp_t e;
    push_scan(32'h11001001);
    start_pulse();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL dec_busy got=%b want=1", bus.busy); end
    wait_done(TXN + 20, lat, ok);
    e = pop_exp();
    total++; if (!ok || lat != TXN) begin bad++; $display("FAIL dec_latency got=%0d (seen=%0b) want=%0d", lat, ok, TXN); end
    total++; if (rises != 8)        begin bad++; $display("FAIL cmd_rises got=%0d want=8", rises); end
    total++; if (cmd_bits !== 8'h42) begin bad++; $display("FAIL cmd_bits got=%h want=42", cmd_bits); end
    total++; if (bus.scan !== e.scan) begin bad++; $display("FAIL dec_scan got=%h want=%h", bus.scan, e.scan); end
    total++; if (bus.keys !== 8'hC9)  begin bad++; $display("FAIL dec_keys got=%h want=c9", bus.keys); end
    total++; if (bus.key_change !== e.kc) begin bad++; $display("FAIL dec_kc got=%b want=%b", bus.key_change, e.kc); end
    total++; if (bus.busy !== 1'b0)   begin bad++; $display("FAIL dec_busy_at_done got=%b want=0", bus.busy); end
    @(negedge clkinput);
    total++; if (bus.done !== 1'b0)   begin bad++; $display("FAIL dec_done_width got=%b want=0", bus.done); end
  endtask

  task automatic test_repeat();
    int lat; bit ok; exp_t e;
    push_scan(32'h11001001);
    start_pulse();
    wait_done(TXN + 20, lat, ok);
    e = pop_exp();
    total++; if (!ok || lat != TXN)      begin bad++; $display("FAIL rep_latency got=%0d (seen=%0b) want=%0d", lat, ok, TXN); end
    total++; if (bus.key_change !== 1'b0) begin bad++; $display("FAIL rep_kc got=%b want=0", bus.key_change); end
    total++; if (bus.keys !== e.keys)    begin bad++; $display("FAIL rep_keys got=%h want=%h", bus.keys, e.keys); end
    push_scan(32'h0);
    start_pulse();
    wait_done(TXN + 20, lat, ok);
    e = pop_exp();
    total++; if (!ok)                     begin bad++; $display("FAIL zero_done got=timeout want=done"); end
    total++; if (bus.keys !== 8'h00)      begin bad++; $display("FAIL zero_keys got=%h want=00", bus.keys); end
    total++; if (bus.key_change !== e.kc) begin bad++; $display("FAIL zero_kc got=%b want=%b", bus.key_change, e.kc); end
  endtask

  task automatic test_back_to_back();
    int lat; bit ok; exp_t e; int falls0;
    push_scan(32'h00100001);
    push_scan(32'h01000010);
    @(negedge clkinput);
    falls0    = stb_falls;
    bus.start = 1'b1;
    wait_done(TXN + 20, lat, ok);
    e = pop_exp();
    total++; if (!ok)                    begin bad++; $display("FAIL b2b1_done got=timeout want=done"); end
    total++; if (bus.scan !== e.scan)    begin bad++; $display("FAIL b2b1_scan got=%h want=%h", bus.scan, e.scan); end
    total++; if (bus.keys !== e.keys)    begin bad++; $display("FAIL b2b1_keys got=%h want=%h", bus.keys, e.keys); end
    // Second scan is accepted at the end of the first done cycle.
    wait_done(TXN + 20, lat, ok);
    bus.start = 1'b0;
    e = pop_exp();
    total++; if (!ok || lat != TXN + 1)  begin bad++; $display("FAIL b2b2_latency got=%0d (seen=%0b) want=%0d", lat, ok, TXN + 1); end
    total++; if (bus.scan !== e.scan)    begin bad++; $display("FAIL b2b2_scan got=%h want=%h", bus.scan, e.scan); end
    total++; if (bus.keys !== e.keys)    begin bad++; $display("FAIL b2b2_keys got=%h want=%h", bus.keys, e.keys); end
    total++; if (bus.key_change !== e.kc) begin bad++; $display("FAIL b2b2_kc got=%b want=%b", bus.key_change, e.kc); end
    // STB_HI tick plus the single idle cycle in which start is sampled.
    total++; if (last_hi_run != CLK_DIV + 1) begin bad++; $display("FAIL b2b_stb_gap got=%0d want=%0d", last_hi_run, CLK_DIV + 1); end
    repeat (TXN / 2) @(negedge clkinput);
    total++; if (stb_falls - falls0 != 2) begin bad++; $display("FAIL b2b_txn_count got=%0d want=2", stb_falls - falls0); end
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL b2b_idle_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    int lat; bit ok; exp_t e; int done_seen;
    push_scan(32'hFFFFFFFF);
    start_pulse();
    // READ tick 30 starts (1 + 16 + TWAIT + 30) ticks after the accept edge.
    repeat ((19 + 30) * CLK_DIV + 1) @(negedge clkinput);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.tm_stb !== 1'b1)     begin bad++; $display("FAIL mid_stb got=%b want=1", bus.tm_stb); end
    total++; if (bus.tm_dio_oe !== 1'b0)  begin bad++; $display("FAIL mid_oe got=%b want=0", bus.tm_dio_oe); end
    total++; if (bus.tm_clk !== 1'b1)     begin bad++; $display("FAIL mid_clk got=%b want=1", bus.tm_clk); end
    total++; if (bus.busy !== 1'b0)       begin bad++; $display("FAIL mid_busy got=%b want=0", bus.busy); end
    total++; if (bus.scan !== 32'h0)      begin bad++; $display("FAIL mid_scan got=%h want=0", bus.scan); end
    total++; if (bus.keys !== 8'h0)       begin bad++; $display("FAIL mid_keys got=%h want=0", bus.keys); end
    void'(exp_q.pop_back());
    model_keys = '0;
    repeat (3) @(negedge clkinput);
    rst_n     = 1'b1;
    done_seen = 0;
    for (int i = 0; i < TXN; i++) begin
      @(negedge clkinput);
      if (bus.done === 1'b1) done_seen++;
    end
    total++; if (done_seen != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", done_seen); end
    push_scan(32'h00000011);
    start_pulse();
    wait_done(TXN + 20, lat, ok);
    e = pop_exp();
    total++; if (!ok || lat != TXN)       begin bad++; $display("FAIL post_latency got=%0d (seen=%0b) want=%0d", lat, ok, TXN); end
    total++; if (bus.scan !== e.scan)     begin bad++; $display("FAIL post_scan got=%h want=%h", bus.scan, e.scan); end
    total++; if (bus.keys !== 8'h03)      begin bad++; $display("FAIL post_keys got=%h want=03", bus.keys); end
    total++; if (bus.key_change !== e.kc) begin bad++; $display("FAIL post_kc got=%b want=%b", bus.key_change, e.kc); end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_key_decode();
    test_repeat();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
